// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decodes the ID opcode and carries its control bundle through ID/EX, EX/MEM, MEM/WB with hazard/stall/flush handling.
// Ports: clk, rst_n (async low); ext_stall freezes everything; id_* describe the ID instruction;
// hz_stall/if_flush/br_jmp are combinational front-end controls; ex_*/mem_*/wb_* are per-stage controls;
// illegal pulses after an illegal opcode leaves ID; stall_cnt saturates on hazard stalls.
module ctrl_pipe #(
  parameter int OPW = 4,
  parameter int RAW = 4,
  parameter int CNTW = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ext_stall,
  input  logic            id_valid,
  input  logic [OPW-1:0]  id_opcode,
  input  logic [RAW-1:0]  id_rs,
  input  logic [RAW-1:0]  id_rt,
  input  logic [RAW-1:0]  id_dst,
  input  logic            id_br_taken,
  output logic            hz_stall,
  output logic            if_flush,
  output logic            br_jmp,
  output logic            illegal,
  output logic [1:0]      ex_alu_op,
  output logic            ex_alu_sel0,
  output logic            ex_alu_sel1,
  output logic            ex_reg_swp,
  output logic            mem_rd,
  output logic            mem_wrt,
  output logic            mem_byte,
  output logic            wb_reg_wrt,
  output logic [1:0]      wb_reg_src,
  output logic [RAW-1:0]  wb_dst,
  output logic [CNTW-1:0] stall_cnt
);
  // Bundle layout: {aluOp[1:0], sel0, sel1, rd, wrt, byte, regWrt, regSrc[1:0]}
  logic [9:0] dec, idEx;
  logic [5:0] exMem;
  logic [2:0] memWb;
  logic [RAW-1:0] idExDst, exMemDst, memWbDst;
  logic isBr, isJmp, legal, upperNz, illegalOp;
  assign upperNz = |(id_opcode >> 4);
  always_comb begin
    dec = '0;
    isBr = 1'b0;
    isJmp = 1'b0;
    legal = 1'b1;
    case (id_opcode[3:0])
      4'b1111: dec = 10'b00_0_0_0_0_0_1_10;
      4'b1000: dec = 10'b00_0_1_0_0_0_1_10;
      4'b1001: dec = 10'b11_0_1_0_0_0_1_10;
      4'b1010: dec = 10'b10_1_0_1_0_1_1_00;
      4'b1011: dec = 10'b10_1_0_0_1_1_0_00;
      4'b1100: dec = 10'b10_1_0_1_0_0_1_00;
      4'b1101: dec = 10'b10_1_0_0_1_0_0_00;
      4'b0100, 4'b0101, 4'b0110: isBr = 1'b1;
      4'b0001: isJmp = 1'b1;
      default: legal = 1'b0;
    endcase
    if (upperNz || !id_valid) begin
      dec = '0;
      isBr = 1'b0;
      isJmp = 1'b0;
    end
  end
  assign illegalOp = id_valid & (upperNz | ~legal);
  assign hz_stall = (HAZARD_EN != 0) && !ext_stall && id_valid && idEx[5] &&
                    (idExDst == id_rs || idExDst == id_rt);
  assign if_flush = id_valid & ~hz_stall & ~ext_stall & (isJmp | (isBr & id_br_taken));
  assign br_jmp = isJmp;
  assign ex_alu_op = idEx[9:8];
  assign ex_alu_sel0 = idEx[7];
  assign ex_alu_sel1 = idEx[6];
  assign ex_reg_swp = 1'b0;
  assign mem_rd = exMem[5];
  assign mem_wrt = exMem[4];
  assign mem_byte = exMem[3];
  assign wb_reg_wrt = memWb[2];
  assign wb_reg_src = memWb[1:0];
  assign wb_dst = memWbDst;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idEx <= '0;
      idExDst <= '0;
      exMem <= '0;
      exMemDst <= '0;
      memWb <= '0;
      memWbDst <= '0;
      illegal <= 1'b0;
      stall_cnt <= '0;
    end else if (!ext_stall) begin
      idEx <= hz_stall ? '0 : dec;
      // Bubbles carry dst 0 so a stale address never looks like a live load target.
      idExDst <= (hz_stall || dec == '0) ? '0 : id_dst;
      exMem <= idEx[5:0];
      exMemDst <= idExDst;
      memWb <= exMem[2:0];
      memWbDst <= exMemDst;
      illegal <= illegalOp & ~hz_stall;
      if (hz_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNTW'(1);
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: randomized scoreboard bench for ctrl_pipe against an instruction-level pipeline model.
module tb_ctrl_pipe;
  localparam int OPW = 6, RAW = 4, CNTW = 3, NCYC = 800;
  logic clk = 0, rst_n = 0, ext_stall = 0, id_valid = 0, id_br_taken = 0;
  logic [OPW-1:0] id_opcode = '0;
  logic [RAW-1:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic hz_stall, if_flush, br_jmp, illegal, ex_alu_sel0, ex_alu_sel1, ex_reg_swp;
  logic mem_rd, mem_wrt, mem_byte, wb_reg_wrt;
  logic [1:0] ex_alu_op, wb_reg_src;
  logic [RAW-1:0] wb_dst;
  logic [CNTW-1:0] stall_cnt;
  ctrl_pipe #(.OPW(OPW), .RAW(RAW), .CNTW(CNTW), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_br_taken(id_br_taken), .hz_stall(hz_stall), .if_flush(if_flush),
    .br_jmp(br_jmp), .illegal(illegal), .ex_alu_op(ex_alu_op),
    .ex_alu_sel0(ex_alu_sel0), .ex_alu_sel1(ex_alu_sel1), .ex_reg_swp(ex_reg_swp),
    .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_byte(mem_byte),
    .wb_reg_wrt(wb_reg_wrt), .wb_reg_src(wb_reg_src), .wb_dst(wb_dst),
    .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  typedef struct packed {logic [OPW-1:0] op; logic [RAW-1:0] dst; logic live;} slot_t;
  typedef struct {
    logic hz, flush, brj, ill, sel0, sel1, rd, wrt, mb, regWrt;
    logic [1:0] aluOp, regSrc;
    logic [RAW-1:0] dst;
    logic [CNTW-1:0] cnt;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  // Spec control table: {aluOp, sel0, sel1, rd, wrt, byte, regWrt, regSrc}; anything else is a bubble.
  function automatic logic [9:0] ctl(input logic [OPW-1:0] op);
    case (op)
      6'h0F: return 10'b0000000110;
      6'h08: return 10'b0001000110;
      6'h09: return 10'b1101000110;
      6'h0A: return 10'b1010101100;
      6'h0B: return 10'b1010011000;
      6'h0C: return 10'b1010100100;
      6'h0D: return 10'b1010010000;
      default: return 10'b0;
    endcase
  endfunction
  function automatic bit isCf(input logic [OPW-1:0] op);
    return op == 6'h01 || op == 6'h04 || op == 6'h05 || op == 6'h06;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, want);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hz_stall", 32'(hz_stall), 32'(e.hz));
      chk("if_flush", 32'(if_flush), 32'(e.flush));
      if (e.flush) chk("br_jmp", 32'(br_jmp), 32'(e.brj));
      chk("illegal", 32'(illegal), 32'(e.ill));
      chk("ex_alu_op", 32'(ex_alu_op), 32'(e.aluOp));
      chk("ex_alu_sel0", 32'(ex_alu_sel0), 32'(e.sel0));
      chk("ex_alu_sel1", 32'(ex_alu_sel1), 32'(e.sel1));
      chk("ex_reg_swp", 32'(ex_reg_swp), 32'(0));
      chk("mem_rd", 32'(mem_rd), 32'(e.rd));
      chk("mem_wrt", 32'(mem_wrt), 32'(e.wrt));
      chk("mem_byte", 32'(mem_byte), 32'(e.mb));
      chk("wb_reg_wrt", 32'(wb_reg_wrt), 32'(e.regWrt));
      chk("wb_reg_src", 32'(wb_reg_src), 32'(e.regSrc));
      chk("wb_dst", 32'(wb_dst), 32'(e.dst));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    slot_t ex = '0, mem = '0, wb = '0;
    logic ill = 0, hold = 0;
    logic [CNTW-1:0] cnt = '0;
    logic [OPW-1:0] ops[15] = '{6'h0F, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                6'h04, 6'h05, 6'h06, 6'h01, 6'h0C, 6'h0A, 6'h03, 6'h10};
    for (int c = 0; c < NCYC; c++) begin
      exp_t e;
      logic [9:0] cx, cm, cw;
      @(posedge clk);
      #1;
      rst_n = !(c < 2 || $urandom_range(0, 149) == 0);
      ext_stall = hold && ext_stall ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
      if (!rst_n) begin
        id_valid = 0;
        ext_stall = 0;
      end else if (!hold) begin
        id_valid = $urandom_range(0, 7) != 0;
        id_opcode = $urandom_range(0, 19) == 0 ? OPW'($urandom_range(0, 63)) : ops[$urandom_range(0, 14)];
        id_rs = RAW'($urandom_range(0, 3));
        id_rt = RAW'($urandom_range(0, 3));
        id_dst = RAW'($urandom_range(0, 3));
        id_br_taken = 1'($urandom_range(0, 1));
      end
      cx = ex.live ? ctl(ex.op) : '0;
      cm = mem.live ? ctl(mem.op) : '0;
      cw = wb.live ? ctl(wb.op) : '0;
      e.hz = rst_n && id_valid && !ext_stall && ex.live && cx[5] && (ex.dst == id_rs || ex.dst == id_rt);
      e.flush = rst_n && id_valid && !e.hz && !ext_stall &&
                (id_opcode == 6'h01 || (isCf(id_opcode) && id_br_taken));
      e.brj = id_opcode == 6'h01;
      e.ill = rst_n && ill;
      e.aluOp = rst_n ? cx[9:8] : 2'b0;
      e.sel0 = rst_n && cx[7];
      e.sel1 = rst_n && cx[6];
      e.rd = rst_n && cm[5];
      e.wrt = rst_n && cm[4];
      e.mb = rst_n && cm[3];
      e.regWrt = rst_n && cw[2];
      e.regSrc = rst_n ? cw[1:0] : 2'b0;
      e.dst = rst_n && wb.live ? wb.dst : '0;
      e.cnt = rst_n ? cnt : '0;
      q.push_back(e);
      if (!rst_n) begin
        ex = '0; mem = '0; wb = '0; ill = 0; cnt = '0;
      end else if (!ext_stall) begin
        wb = mem;
        mem = ex;
        ex = (e.hz || !id_valid || ctl(id_opcode) == '0) ? '0 : '{id_opcode, id_dst, 1'b1};
        ill = id_valid && !e.hz && ctl(id_opcode) == '0 && !isCf(id_opcode);
        if (e.hz && cnt != '1) cnt++;
      end
      hold = rst_n && (e.hz || ext_stall);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) chk("drain", 32'(q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined control unit for the 4-stage-control MIPS-style core (ID/EX/MEM/WB); successor to the combinational opcode decoder.
- Decodes the ID-stage opcode into a fully defined control bundle (no don't-cares) and carries it through ID/EX, EX/MEM and MEM/WB registers alongside the destination register address.
- Adds load-use hazard detection with bubble insertion, a global external stall, branch/jump flush generation, illegal-opcode flagging and a saturating stall counter.

Parameters:
- OPW, 4, opcode width; must be >= 4; bits above [3:0] must be zero for a legal opcode.
- RAW, 4, register address width.
- CNTW, 16, stall counter width.
- HAZARD_EN, 1, 1 = load-use detection active; 0 = never stall internally.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ext_stall  in  1  freeze all stage registers (memory wait)
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  OPW  ID-stage opcode
- id_rs  in  RAW  ID source register 1
- id_rt  in  RAW  ID source register 2
- id_dst  in  RAW  ID destination register
- id_br_taken  in  1  ID comparator result for the conditional branch in ID
- hz_stall  out  1  hold PC and IF/ID (combinational)
- if_flush  out  1  squash IF/ID (combinational)
- br_jmp  out  1  1 = jump target, 0 = branch target; valid when if_flush
- illegal  out  1  registered pulse, one cycle after an illegal valid opcode leaves ID
- ex_alu_op  out  2  EX ALU op
- ex_alu_sel0, ex_alu_sel1, ex_reg_swp  out  1 each  EX operand controls
- mem_rd, mem_wrt, mem_byte  out  1 each  MEM controls
- wb_reg_wrt  out  1  WB register write
- wb_reg_src  out  2  WB source mux select
- wb_dst  out  RAW  WB destination register
- stall_cnt  out  CNTW  saturating count of hz_stall cycles

Behaviour:
- Reset (async, rst_n=0): all stage registers cleared to the bubble (every control 0, dst 0). illegal=0, stall_cnt=0.
- Decode (opcode[3:0], upper bits zero). Fields are alu_op/sel0/sel1/rd/wrt/byte/reg_wrt/reg_src:
  - 1111 typeA: 00/0/0/0/0/0/1/10
  - 1000 and: 00/0/1/0/0/0/1/10
  - 1001 or: 11/0/1/0/0/0/1/10
  - 1010 lbu: 10/1/0/1/0/1/1/00
  - 1011 sb: 10/1/0/0/1/1/0/00
  - 1100 lw: 10/1/0/1/0/0/1/00
  - 1101 sw: 10/1/0/0/1/0/0/00
- Decode, control flow:
  - 0101 blt, 0100 bgt, 0110 beq: conditional branch; bundle is a bubble.
  - 0001 jmp: jump; bundle is a bubble.
  - reg_swp is always 0.
- Illegal opcode: any other value, or any nonzero upper bit. Decoded as a bubble; illegal=1 for one cycle after it advances out of ID.
- id_valid=0: decoded as a bubble; no flush, no hazard.
- Latency: an instruction in ID at cycle N presents its EX controls at N+1, MEM at N+2, WB (with wb_dst) at N+3, absent stalls.
- Load-use hazard: asserted when HAZARD_EN, id_valid, EX holds mem_rd=1, and EX dst equals id_rs or id_rt. hz_stall=1; next edge loads a bubble into ID/EX while EX/MEM and MEM/WB advance. Lasts exactly one cycle per load.
- if_flush: asserted when id_valid, no hz_stall, no ext_stall, and either the opcode is a jump or it is a conditional branch with id_br_taken=1. br_jmp=1 only for a jump.
- Branch whose operand is hazarded: hz_stall wins and if_flush=0 that cycle. Flush is evaluated again after the bubble.
- ext_stall=1: every stage register holds and illegal holds. if_flush=0, hz_stall=0, stall_cnt unchanged. ext_stall has highest priority, then hazard, then flush.
- stall_cnt: +1 on each edge with hz_stall=1 and ext_stall=0; saturates at all-ones with no wrap.
- Reset mid-operation: pipeline contents are discarded immediately; outputs read bubble values while rst_n=0.

Test Plan:
- Reset, then lw (1100) in ID at cycle 0 with id_dst=3 -> ex_alu_op=10, ex_alu_sel0=1 at c1; mem_rd=1 at c2; wb_reg_wrt=1, wb_reg_src=00, wb_dst=3 at c3.
- lw dst=5, followed by or (1001) with id_rs=5 -> hz_stall=1 for exactly 1 cycle; bubble in EX; or reaches WB one cycle late; stall_cnt=1.
- beq (0110) with id_br_taken=1 -> if_flush=1, br_jmp=0 same cycle; with id_br_taken=0 -> if_flush=0. jmp (0001) -> if_flush=1, br_jmp=1.
- lw dst=2, then beq with id_rt=2, id_br_taken=1 -> c0: hz_stall=1, if_flush=0; c1: if_flush=1.
- Opcode 0011 and (OPW=6) 010000 -> illegal pulses 1 cycle later; all downstream controls 0. ext_stall held for 3 cycles mid-stream -> outputs frozen, stall_cnt unchanged.
- CNTW=2, 5 load-use stalls -> stall_cnt=3 (saturated). Deassert rst_n mid-pipeline -> all outputs 0 asynchronously.
